// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   Multiply is shift-add, divide is restoring; both take one operand bit per
//   cycle, so the unit is busy for WIDTH cycles plus one completion cycle.
//   Operands are reduced to magnitudes when accepted and the sign is fixed up
//   on the final step, so the iteration core is purely unsigned.
//
// Build option:
//   MULDIV_DIV_EN  When defined, the divider is built.
//                  When undefined, divide requests are never accepted and
//                  div_by_zero is tied low.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (priority over everything)
//   start        request an operation, sampled only while ready
//   is_div       0 = multiply, 1 = divide (sampled with start)
//   m_signed     1 = two's-complement operands (sampled with start)
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   hi_we/lo_we  write wr_data into HI/LO (only while ready)
//   wr_data      HI/LO write data
//   ready        idle, able to accept start
//   busy         ~ready, used as a pipeline stall
//   done         one-cycle completion pulse
//   div_by_zero  valid with done: divide with zero divisor
//   hi, lo       architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             m_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    // acc_reg: running upper product / partial remainder
    // low_reg: multiplier bits shifting out / dividend bits shifting out,
    //          quotient bits shifting in
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] low_reg, low_next;
    logic [WIDTH-1:0] opb_reg;          // multiplicand or divisor magnitude
    logic             neg_res_reg;      // product / quotient must be negated
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [WIDTH-1:0] res_hi, res_lo;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept, last_step;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;

`ifdef MULDIV_DIV_EN
    logic             div_reg;
    logic             neg_rem_reg;      // remainder follows dividend sign
    logic             dz_reg;
    logic [WIDTH-1:0] a_orig_reg;       // returned in HI on divide by zero
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] rem_diff;
    logic [WIDTH-1:0] div_acc, div_low;
    assign accept = (state_reg == IDLE) && start;
`else
    assign accept = (state_reg == IDLE) && start && !is_div;
`endif

    assign a_mag     = (m_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag     = (m_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign last_step = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_step) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state_reg == IDLE);
    assign busy  = ~ready;
    assign done  = (state_reg == FIN);
    assign hi    = hi_reg;
    assign lo    = lo_reg;

`ifdef MULDIV_DIV_EN
    assign div_by_zero = done && dz_reg;
`else
    assign div_by_zero = 1'b0;
`endif

    // ---------------------------------------------------------- datapath
    always_comb begin
        // Shift-add step: add multiplicand when the current multiplier bit
        // is set, then shift {carry, acc, low} right by one.
        mul_sum  = {1'b0, acc_reg} + {1'b0, (low_reg[0] ? opb_reg : {WIDTH{1'b0}})};
        acc_next = mul_sum[WIDTH:1];
        low_next = {mul_sum[0], low_reg[WIDTH-1:1]};

        prod_raw = {acc_next, low_next};
        prod_fix = neg_res_reg ? -prod_raw : prod_raw;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];

`ifdef MULDIV_DIV_EN
        // Restoring step: bring in next dividend bit, subtract divisor if it
        // fits; the extra top bit of rem_diff is the borrow.
        rem_shift = {acc_reg, low_reg[WIDTH-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, opb_reg};
        if (!rem_diff[WIDTH+1]) begin
            div_acc = rem_diff[WIDTH-1:0];
            div_low = {low_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = rem_shift[WIDTH-1:0];
            div_low = {low_reg[WIDTH-2:0], 1'b0};
        end
        if (div_reg) begin
            acc_next = div_acc;
            low_next = div_low;
            if (dz_reg) begin
                res_hi = a_orig_reg;
                res_lo = {WIDTH{1'b1}};
            end else begin
                // most-negative / -1 falls out naturally: the magnitude
                // quotient 2^(W-1) is its own negation.
                res_hi = neg_rem_reg ? -div_acc : div_acc;
                res_lo = neg_res_reg ? -div_low : div_low;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            low_reg     <= '0;
            opb_reg     <= '0;
            neg_res_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MULDIV_DIV_EN
            div_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            dz_reg      <= 1'b0;
            a_orig_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (hi_we) hi_reg <= wr_data;
                if (lo_we) lo_reg <= wr_data;
                if (accept) begin
                    cnt_reg     <= '0;
                    acc_reg     <= '0;
                    low_reg     <= a_mag;
                    opb_reg     <= b_mag;
                    neg_res_reg <= m_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                    div_reg     <= is_div;
                    neg_rem_reg <= m_signed && src_a[WIDTH-1];
                    dz_reg      <= is_div && (src_b == '0);
                    a_orig_reg  <= src_a;
`endif
                end
            end else if (state_reg == RUN) begin
                acc_reg <= acc_next;
                low_reg <= low_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_step) begin
                    hi_reg <= res_hi;
                    lo_reg <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32). Expected values are hand-computed.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, is_div, m_signed, hi_we, lo_we;
    logic [31:0] src_a, src_b, wr_data;
    logic        ready, busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_div(is_div),
        .m_signed(m_signed), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .ready(ready), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Presents a request; returns 1 ns after the edge that samples it.
    task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; is_div = d; m_signed = s; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (0 = never within bound).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int lat;
        issue(d, s, a, b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dz));
        @(posedge clk); #1;
        check({tag, " pulse end"}, 64'(done), 64'd0);
        check({tag, " ready back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        int lat, nd;
        reset = 1'b1; start = 1'b0; is_div = 1'b0; m_signed = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; src_a = '0; src_b = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst ready", 64'(ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);

        // mtlo in IDLE
        @(negedge clk); lo_we = 1'b1; wr_data = 32'hABCD;
        @(posedge clk); #1 lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'hABCD);

        // Multiplies
        run_op("umul ff*ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("smul -3*7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("umul x*16", 1'b0, 1'b0, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0);
        run_op("smul -1*-1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);

        // start + mthi while busy are ignored; operands latched at accept
        @(negedge clk); hi_we = 1'b1; wr_data = 32'h5555;
        @(posedge clk); #1 hi_we = 1'b0;
        check("mthi pre", 64'(hi), 64'h5555);
        issue(1'b0, 1'b0, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; src_a = 32'd9; src_b = 32'd9; hi_we = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy mthi ignored", 64'(hi), 64'h5555);
        check("busy still", 64'(busy), 64'd1);
        wait_done(lat);
        check("busy op latency", 64'(lat), 64'd28);
        check("busy op hi", 64'(hi), 64'd0);
        check("busy op lo", 64'(lo), 64'd42);
        count_done(36, nd);
        check("no queued op", 64'(nd), 64'd0);

        // mthi in IDLE
        @(negedge clk); hi_we = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1 hi_we = 1'b0;
        check("mthi idle", 64'(hi), 64'h1234);

        // mtlo coinciding with accepted start
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; m_signed = 1'b0; src_a = 32'd2; src_b = 32'd3;
        lo_we = 1'b1; wr_data = 32'hBEEF;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        check("mtlo at accept", 64'(lo), 64'hBEEF);
        wait_done(lat);
        check("mtlo op latency", 64'(lat), 64'd32);
        check("mtlo op lo", 64'(lo), 64'd6);
        check("mtlo op hi", 64'(hi), 64'd0);
        @(posedge clk); #1;

        // Reset 10 cycles into RUN
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrun rst ready", 64'(ready), 64'd1);
        check("midrun rst busy", 64'(busy), 64'd0);
        check("midrun rst hi", 64'(hi), 64'd0);
        check("midrun rst lo", 64'(lo), 64'd0);
        check("midrun rst done", 64'(done), 64'd0);
        count_done(40, nd);
        check("midrun no done", 64'(nd), 64'd0);

`ifdef MULDIV_DIV_EN
        run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("udiv 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div 5/0", 1'b1, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("sdiv min/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("sdiv 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
`else
        // Divider absent: divide request is refused
        @(negedge clk);
        start = 1'b1; is_div = 1'b1; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        check("nodiv ready", 64'(ready), 64'd1);
        count_done(40, nd);
        check("nodiv no done", 64'(nd), 64'd0);
        check("nodiv lo", 64'(lo), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
